// File: rtl/switch_debouncer.sv
// Two-flop synchronizer feeding a four-state debounce FSM with a saturating stability counter.
// Define SWITCH_DEBOUNCER_PULSE_EN to build the rise/fall strobes; otherwise they are tied to 0.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic sw_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sw_out_q, sw_out_d;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      sw_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_out_q <= sw_out_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    sw_out_d = sw_out_q;
    unique case (state_q)
      STABLE_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_HIGH;
          cnt_d    = '0;
          sw_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_LOW;
          cnt_d    = '0;
          sw_out_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign sw_out = sw_out_q;

`ifdef SWITCH_DEBOUNCER_PULSE_EN
  logic rise_q, fall_q;

  // sw_out_d differs from sw_out_q only on an accepted transition, so the strobes share its edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= sw_out_d & ~sw_out_q;
      fall_q <= ~sw_out_d & sw_out_q;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 1000, giving the number of consecutive clock cycles a new input level must persist before it is accepted; legal range 2 .. 2**CNT_WIDTH-1.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, giving the width of the stability counter in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port sw_in, input, 1 bit: raw, asynchronous, bouncing switch level.
REQ-006 The module SHALL have port sw_out, output, 1 bit: debounced, registered switch level for downstream logic such as the LED inverter.
REQ-007 The module SHALL have port rise_pulse, output, 1 bit: one-cycle strobe when sw_out goes 0->1.
REQ-008 The module SHALL have port fall_pulse, output, 1 bit: one-cycle strobe when sw_out goes 1->0.

Function
REQ-009 sw_in SHALL pass through a two-flop synchronizer (sync1, sync2); only sync2 feeds the FSM.
REQ-010 The FSM SHALL have four states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH and WAIT_LOW.
REQ-011 In STABLE_LOW, sync2=1 SHALL move the FSM to WAIT_HIGH with counter=1; otherwise the FSM stays and counter=0.
REQ-012 In WAIT_HIGH, sync2=1 with counter<DEBOUNCE_CYCLES-1 SHALL increment the counter.
REQ-013 In WAIT_HIGH, sync2=1 with counter=DEBOUNCE_CYCLES-1 SHALL move the FSM to STABLE_HIGH, set sw_out=1 and clear the counter.
REQ-014 In WAIT_HIGH, sync2=0 SHALL return the FSM to STABLE_LOW with counter cleared; sw_out stays unchanged and no pulse is issued.
REQ-015 STABLE_HIGH and WAIT_LOW SHALL mirror REQ-011..REQ-014 with the polarity inverted.
REQ-016 Latency: if sw_in is at a new level from sampling edge k onward, sw_out SHALL take that level on edge k+DEBOUNCE_CYCLES+1 and not earlier.
REQ-017 sw_out SHALL change only on accepted transitions; any excursion of sync2 shorter than DEBOUNCE_CYCLES cycles SHALL leave all outputs unchanged.
REQ-018 The counter SHALL never wrap: its maximum value is DEBOUNCE_CYCLES-1 and it is cleared in both STABLE states.
REQ-019 rise_pulse and fall_pulse SHALL be registered and asserted for exactly one cycle, on the same edge that updates sw_out; they SHALL never be asserted together.
REQ-020 All outputs SHALL be driven directly from flops, with no combinational path from sw_in.

Reset
REQ-021 While rst=1 at a rising edge, sync1, sync2, counter, sw_out, rise_pulse and fall_pulse SHALL be cleared to 0 and the FSM SHALL enter STABLE_LOW.
REQ-022 rst SHALL take priority over all other events, including an assertion mid-WAIT (count discarded) and an assertion on the edge of an accepted transition (no pulse issued).
REQ-023 After rst is released with sw_in held high, sw_out SHALL rise by the REQ-016 timing, counting the first post-reset edge as k, and SHALL issue one rise_pulse.

Configuration
REQ-024 Macro SWITCH_DEBOUNCER_PULSE_EN, when defined, SHALL compile in the rise_pulse and fall_pulse registers and logic.
REQ-025 When SWITCH_DEBOUNCER_PULSE_EN is undefined, rise_pulse and fall_pulse SHALL remain ports tied constantly to 0, and sw_out behaviour SHALL be identical to the defined case.

Verification (DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-026 Scenario: rst=1 for 3 cycles with sw_in=1, then rst=0 -> all outputs 0 during reset; sw_out=1 and a single rise_pulse on the 5th edge after release.
REQ-027 Scenario: clean press, sw_in 0->1 before edge 10 and held -> sw_out=1 after edge 15; rise_pulse=1 only in the cycle after edge 15.
REQ-028 Scenario: glitch, sw_in=1 for 3 cycles then 0 -> sw_out stays 0 and no pulse occurs; likewise a 3-cycle low glitch while sw_out=1 leaves it at 1.
REQ-029 Scenario: bounce, sw_in toggles every 2 cycles for 20 cycles, then settles at 1 from edge k -> exactly one rise_pulse, with sw_out=1 at edge k+5.
REQ-030 Scenario: rst asserted for 1 cycle while the FSM is in WAIT_HIGH with counter=2 and sw_in stays 1 -> outputs 0 and the count restarts; sw_out rises 5 edges after release.
REQ-031 Scenario: release and macro-off regression, sw_in 1->0 with the macro defined -> one fall_pulse coincident with sw_out 1->0; the same stimulus with the macro undefined -> identical sw_out and both pulse outputs constantly 0.
